// File: rtl/keyboard_pkg.sv
// Shared constants, FSM state type and PS/2 set-2 scancode map for the
// matrix keyboard emulator.
package keyboard_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_BAT   = 8'hAA;
  localparam logic [7:0] SC_RESET = 8'h77;
  localparam logic [7:0] SC_OVR0  = 8'h00;
  localparam logic [7:0] SC_OVR1  = 8'hFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXTBRK
  } kbd_state_t;

  typedef struct packed {
    logic       hit;
    logic [3:0] row;
    logic [2:0] col;
  } key_map_t;

  // Translate {extended, code} into a matrix position; hit = 0 when unmapped.
  function automatic key_map_t map_scancode(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '{hit: 1'b1, row: 4'd0, col: 3'd0};
    case ({ext, code})
      9'h01A: begin m.row = 4'd0;  m.col = 3'd5; end
      9'h022: begin m.row = 4'd0;  m.col = 3'd4; end
      9'h021: begin m.row = 4'd0;  m.col = 3'd3; end
      9'h02A: begin m.row = 4'd0;  m.col = 3'd2; end
      9'h032: begin m.row = 4'd0;  m.col = 3'd1; end
      9'h01C: begin m.row = 4'd1;  m.col = 3'd5; end
      9'h01B: begin m.row = 4'd1;  m.col = 3'd4; end
      9'h023: begin m.row = 4'd1;  m.col = 3'd3; end
      9'h02B: begin m.row = 4'd1;  m.col = 3'd2; end
      9'h034: begin m.row = 4'd1;  m.col = 3'd1; end
      9'h015: begin m.row = 4'd2;  m.col = 3'd5; end
      9'h01D: begin m.row = 4'd2;  m.col = 3'd4; end
      9'h024: begin m.row = 4'd2;  m.col = 3'd3; end
      9'h02D: begin m.row = 4'd2;  m.col = 3'd2; end
      9'h02C: begin m.row = 4'd2;  m.col = 3'd1; end
      9'h016: begin m.row = 4'd3;  m.col = 3'd5; end
      9'h01E: begin m.row = 4'd3;  m.col = 3'd4; end
      9'h026: begin m.row = 4'd3;  m.col = 3'd3; end
      9'h025: begin m.row = 4'd3;  m.col = 3'd2; end
      9'h02E: begin m.row = 4'd3;  m.col = 3'd1; end
      9'h175: begin m.row = 4'd9;  m.col = 3'd3; end
      9'h172: begin m.row = 4'd9;  m.col = 3'd2; end
      9'h16B: begin m.row = 4'd9;  m.col = 3'd1; end
      9'h174: begin m.row = 4'd9;  m.col = 3'd0; end
      9'h029: begin m.row = 4'd10; m.col = 3'd0; end
      9'h05A: begin m.row = 4'd10; m.col = 3'd1; end
      9'h012: begin m.row = 4'd10; m.col = 3'd6; end
      9'h014: begin m.row = 4'd11; m.col = 3'd6; end
      default: m.hit = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_intf.sv
// PS/2 device-to-host byte receiver: synchronises the raw lines, shifts in
// start/8 data/odd parity/stop and strobes VALID or ERROR once per frame.
module ps2_intf (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       ERROR
);

  logic [2:0] clk_sync;
  logic [1:0] data_sync;
  logic [3:0] bit_cnt;
  logic [7:0] shift_q;
  logic       parity_q;
  logic       fall;
  logic       bit_in;

  assign fall   = clk_sync[2] & ~clk_sync[1];
  assign bit_in = data_sync[1];

  // Bring both PS/2 lines into the clk domain; idle level is high.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[1:0], PS2_CLK};
      data_sync <= {data_sync[0], PS2_DATA};
    end
  end

  // Frame assembly on each falling PS/2 clock edge; strobes last one cycle.
  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      bit_cnt  <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      DATA     <= '0;
      VALID    <= 1'b0;
      ERROR    <= 1'b0;
    end else begin
      VALID <= 1'b0;
      ERROR <= 1'b0;
      if (fall) begin
        if (bit_cnt == 4'd0) begin
          if (!bit_in) bit_cnt <= 4'd1;
        end else if (bit_cnt <= 4'd8) begin
          shift_q <= {bit_in, shift_q[7:1]};
          bit_cnt <= bit_cnt + 4'd1;
        end else if (bit_cnt == 4'd9) begin
          parity_q <= bit_in;
          bit_cnt  <= bit_cnt + 4'd1;
        end else begin
          bit_cnt <= 4'd0;
          if (bit_in && (^{shift_q, parity_q})) begin
            DATA  <= shift_q;
            VALID <= 1'b1;
          end else begin
            ERROR <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/ps2_matrix_keyboard.sv
// PS/2 keyboard to row/column key matrix emulator: decodes make/break
// sequences into a key matrix scanned through ka/kd.
module ps2_matrix_keyboard
  import keyboard_pkg::*;
#(
  parameter int ROWS    = 12,
  parameter int COLS    = 7,
  parameter int TIMEOUT = 50000
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ps2_clk,
  input  logic            ps2_data,
  input  logic [ROWS-1:0] ka,
  output logic [COLS-1:0] kd,
  output logic            key_reset,
  output logic            ev_valid,
  output logic            ev_make,
  output logic [3:0]      ev_row,
  output logic [2:0]      ev_col
);

  localparam int            TW        = $clog2(TIMEOUT + 2);
  localparam logic [TW-1:0] TMO_LIMIT = TW'(TIMEOUT);

  logic [7:0]      rx_data;
  logic            rx_valid;
  logic            rx_error;
  kbd_state_t      state_q;
  kbd_state_t      state_d;
  logic [TW-1:0]   tmo_q;
  logic [COLS-1:0] matrix_q [ROWS];
  logic [COLS-1:0] kd_next;
  logic            code_byte;
  logic            ext;
  logic            brk;
  key_map_t        map;
  logic            in_range;
  logic            is_reset_key;
  logic            is_clear;
  logic            is_key;

  ps2_intf u_rx (
    .CLK      (clk),
    .nRESET   (reset_n),
    .PS2_CLK  (ps2_clk),
    .PS2_DATA (ps2_data),
    .DATA     (rx_data),
    .VALID    (rx_valid),
    .ERROR    (rx_error)
  );

  // Prefix state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next prefix state; a byte arriving takes priority over timeout expiry.
  always_comb begin
    state_d   = state_q;
    code_byte = 1'b0;
    ext       = (state_q == ST_EXT) || (state_q == ST_EXTBRK);
    brk       = (state_q == ST_BRK) || (state_q == ST_EXTBRK);
    if (rx_error) begin
      state_d = ST_IDLE;
    end else if (rx_valid) begin
      if (rx_data == SC_EXT) begin
        case (state_q)
          ST_IDLE: state_d = ST_EXT;
          ST_BRK:  state_d = ST_EXTBRK;
          default: state_d = state_q;
        endcase
      end else if (rx_data == SC_BRK && state_q == ST_IDLE) begin
        state_d = ST_BRK;
      end else if (rx_data == SC_BRK && state_q == ST_EXT) begin
        state_d = ST_EXTBRK;
      end else begin
        code_byte = 1'b1;
        state_d   = ST_IDLE;
      end
    end else if (state_q != ST_IDLE && tmo_q == TMO_LIMIT) begin
      state_d = ST_IDLE;
    end
  end

  // Classify the code byte: reset key, matrix clear, or mapped matrix key.
  always_comb begin
    map          = map_scancode(ext, rx_data);
    in_range     = map.hit && (32'(map.row) < ROWS) && (32'(map.col) < COLS);
    is_reset_key = code_byte && !ext && (rx_data == SC_RESET);
    is_clear     = code_byte && ((rx_data == SC_BAT) || (rx_data == SC_OVR0) ||
                                 (rx_data == SC_OVR1));
    is_key       = code_byte && !is_reset_key && !is_clear && in_range;
  end

  // Prefix timeout: runs only while waiting for the rest of a sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           tmo_q <= '0;
    else if (rx_valid || state_d == ST_IDLE) tmo_q <= '0;
    else                                    tmo_q <= tmo_q + 1'b1;
  end

  // Key matrix and reset-key level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < ROWS; r++) matrix_q[r] <= '0;
      key_reset <= 1'b0;
    end else if (is_clear) begin
      for (int r = 0; r < ROWS; r++) matrix_q[r] <= '0;
      key_reset <= 1'b0;
    end else begin
      if (is_reset_key) key_reset <= !brk;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          if (is_key && map.row == 4'(r) && map.col == 3'(c))
            matrix_q[r][c] <= !brk;
    end
  end

  // Event strobe describing the matrix update just applied.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ev_valid <= 1'b0;
      ev_make  <= 1'b0;
      ev_row   <= '0;
      ev_col   <= '0;
    end else begin
      ev_valid <= is_key;
      if (is_key) begin
        ev_make <= !brk;
        ev_row  <= map.row;
        ev_col  <= map.col;
      end
    end
  end

  // Column data seen by the host: OR of all selected rows.
  always_comb begin
    kd_next = '0;
    for (int r = 0; r < ROWS; r++)
      if (ka[r]) kd_next = kd_next | matrix_q[r];
  end

  // Register kd so its latency from ka or the matrix is one cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) kd <= '0;
    else          kd <= kd_next;
  end

endmodule

// File: tb/tb_ps2_matrix_keyboard.sv
// Directed bench for ps2_matrix_keyboard: drives PS/2 frames bit by bit and
// checks matrix, kd, key_reset and event outputs against hand values.
module tb_ps2_matrix_keyboard;

  localparam int ROWS    = 12;
  localparam int COLS    = 7;
  localparam int TIMEOUT = 300;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            ps2_clk = 1'b1;
  logic            ps2_data = 1'b1;
  logic [ROWS-1:0] ka = '0;
  logic [COLS-1:0] kd;
  logic            key_reset;
  logic            ev_valid;
  logic            ev_make;
  logic [3:0]      ev_row;
  logic [2:0]      ev_col;

  int         checks = 0;
  int         errors = 0;
  int         ev_count = 0;
  int         exp_ev = 0;
  logic       seen_make = 1'b0;
  logic [3:0] seen_row = '0;
  logic [2:0] seen_col = '0;

  ps2_matrix_keyboard #(
    .ROWS    (ROWS),
    .COLS    (COLS),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .ka        (ka),
    .kd        (kd),
    .key_reset (key_reset),
    .ev_valid  (ev_valid),
    .ev_make   (ev_make),
    .ev_row    (ev_row),
    .ev_col    (ev_col)
  );

  // 10-unit clock.
  always #5 clk = ~clk;

  // Record every cycle ev_valid is high, sampled away from the active edge.
  always @(negedge clk) begin
    if (ev_valid === 1'b1) begin
      ev_count  = ev_count + 1;
      seen_make = ev_make;
      seen_row  = ev_row;
      seen_col  = ev_col;
    end
  end

  // Global time limit so the bench can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One PS/2 frame, LSB first, odd parity (optionally corrupted).
  task automatic send_frame(input logic [7:0] b, input logic bad_parity);
    logic [10:0] frame;
    frame = {1'b1, (~^b) ^ bad_parity, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      @(negedge clk) ps2_data = frame[i];
      repeat (4) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      ps2_clk = 1'b1;
      repeat (2) @(negedge clk);
    end
    ps2_data = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic [7:0] b);
    send_frame(b, 1'b0);
  endtask

  task automatic check_event(input string tag, input logic make, input logic [3:0] row,
                             input logic [2:0] col);
    check_output({tag, "_count"}, ev_count, exp_ev);
    check_output({tag, "_make"}, seen_make, make);
    check_output({tag, "_row"}, seen_row, row);
    check_output({tag, "_col"}, seen_col, col);
  endtask

  task automatic check_kd(input string tag, input logic [ROWS-1:0] sel, input logic [COLS-1:0] exp);
    @(negedge clk) ka = sel;
    @(negedge clk);
    check_output(tag, kd, exp);
  endtask

  initial begin
    $display("[TB] start");
    ka = '1;
    repeat (5) @(negedge clk);
    check_output("rst_kd", kd, 0);
    check_output("rst_key_reset", key_reset, 0);
    check_output("rst_ev_valid", ev_valid, 0);
    check_output("rst_ev_fields", {ev_make, ev_row, ev_col}, 0);
    reset_n = 1'b1;
    check_kd("empty_kd", 12'hFFF, 7'h00);

    // Make S, then verify exactly one cycle of kd latency from ka.
    ka = 12'h002;
    apply_stimulus(8'h1B);
    exp_ev = 1;
    check_event("make_s", 1'b1, 4'd1, 3'd4);
    check_output("s_kd", kd, 32'h10);
    ka = 12'h000;
    #1 check_output("ka_lat_old", kd, 32'h10);
    @(negedge clk) check_output("ka_lat_zero", kd, 0);
    ka = 12'h002;
    #1 check_output("ka_lat_old0", kd, 0);
    @(negedge clk) check_output("ka_lat_new", kd, 32'h10);
    apply_stimulus(8'hF0); apply_stimulus(8'h1B);
    exp_ev = 2;
    check_event("break_s", 1'b0, 4'd1, 3'd4);
    check_output("s_break_kd", kd, 0);

    // Extended UP make and extended break.
    ka = 12'h200;
    apply_stimulus(8'hE0); apply_stimulus(8'h75);
    exp_ev = 3;
    check_event("make_up", 1'b1, 4'd9, 3'd3);
    check_output("up_kd", kd, 32'h08);
    apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h75);
    exp_ev = 4;
    check_event("break_up", 1'b0, 4'd9, 3'd3);
    check_output("up_break_kd", kd, 0);

    // Prefix discarded after timeout: plain 0x75 is unmapped.
    apply_stimulus(8'hE0);
    repeat (TIMEOUT + 1) @(negedge clk);
    apply_stimulus(8'h75);
    check_output("tmo_count", ev_count, exp_ev);
    check_kd("tmo_kd", 12'hFFF, 7'h00);
    // Prefix still valid well inside the timeout window.
    ka = 12'h200;
    apply_stimulus(8'hE0);
    repeat (100) @(negedge clk);
    apply_stimulus(8'h75);
    exp_ev = 5;
    check_event("slow_up", 1'b1, 4'd9, 3'd3);
    check_output("slow_up_kd", kd, 32'h08);
    apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h75);
    exp_ev = 6;
    check_output("slow_up_brk_count", ev_count, exp_ev);

    // Several keys at once, then self-test byte clears everything.
    apply_stimulus(8'h1A); apply_stimulus(8'h22); apply_stimulus(8'h21); apply_stimulus(8'h1C);
    exp_ev = 10;
    check_event("make_a", 1'b1, 4'd1, 3'd5);
    check_kd("multi_kd", 12'h003, 7'h38);
    check_kd("row0_kd", 12'h001, 7'h38);
    check_kd("row1_kd", 12'h002, 7'h20);
    ka = 12'h003;
    apply_stimulus(8'hAA);
    check_output("bat_count", ev_count, exp_ev);
    check_output("bat_kd", kd, 0);

    // Repeated make and break of a clear key still produce events.
    ka = 12'h002;
    apply_stimulus(8'h1B); apply_stimulus(8'h1B);
    exp_ev = 12;
    check_output("rep_make_count", ev_count, exp_ev);
    check_output("rep_make_kd", kd, 32'h10);
    apply_stimulus(8'hF0); apply_stimulus(8'h1A);
    exp_ev = 13;
    check_event("brk_clear_z", 1'b0, 4'd0, 3'd5);
    apply_stimulus(8'h0D);
    check_output("unmapped_count", ev_count, exp_ev);

    // Reset key: level output only, never in the matrix.
    apply_stimulus(8'h77);
    check_output("rk_make", key_reset, 1);
    check_output("rk_count", ev_count, exp_ev);
    for (int r = 0; r < ROWS; r++) begin
      check_kd("rk_row_kd", ROWS'(1 << r), (r == 1) ? 7'h10 : 7'h00);
    end
    apply_stimulus(8'hF0); apply_stimulus(8'h77);
    check_output("rk_break", key_reset, 0);
    apply_stimulus(8'h77);
    check_output("rk_make2", key_reset, 1);
    apply_stimulus(8'hFF);
    check_output("ovr_key_reset", key_reset, 0);
    check_kd("ovr_kd", 12'hFFF, 7'h00);

    // Reset between break prefix and code: code decoded as a make.
    ka = 12'h002;
    apply_stimulus(8'h1B);
    exp_ev = 14;
    check_output("pre_rst_kd", kd, 32'h10);
    apply_stimulus(8'hF0);
    @(negedge clk) reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_output("mid_rst_kd", kd, 0);
    check_output("mid_rst_ev_valid", ev_valid, 0);
    check_output("mid_rst_ev_fields", {ev_make, ev_row, ev_col}, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("post_rst_kd", kd, 0);
    apply_stimulus(8'h1B);
    exp_ev = 15;
    check_event("post_rst_make", 1'b1, 4'd1, 3'd4);
    check_output("post_rst_s_kd", kd, 32'h10);

    // Receiver error drops the pending prefix but keeps the matrix.
    apply_stimulus(8'hE0);
    send_frame(8'h5A, 1'b1);
    apply_stimulus(8'h75);
    check_output("err_count", ev_count, exp_ev);
    check_output("err_kd", kd, 32'h10);
    check_kd("err_enter_kd", 12'h400, 7'h00);
    ka = 12'h002;
    apply_stimulus(8'h1C);
    exp_ev = 16;
    check_event("err_recover", 1'b1, 4'd1, 3'd5);
    check_output("err_recover_kd", kd, 32'h30);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
